sseg_field_display: RTL and testbench

Parametrised seven-segment display controller that drives NUM_FIELDS two-digit decimal fields, such as hours:mins:secs or mins:secs:hundredths. It has one shared blink generator, a selectable field to blink for editing, and an optional zero-reached alert state machine. It sits between the timekeeping, stopwatch and countdown cores and the HEX pins, and it replaces the per-mode fixed-width display wrappers.

---
 rtl/sseg_field_display_pkg.sv | 22 ++
 rtl/sseg_digit_enc.sv | 18 +
 rtl/sseg_field_display.sv | 123 ++++++++++++
 tb/tb_sseg_field_display.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_field_display_pkg.sv
// Shared constants, alert state type and sel-width helper for the seven-segment field display.
package disp_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ALERT = 2'd2,
    LOCK  = 2'd3
  } alert_state_t;

  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sseg_digit_enc.sv
// Combinational BCD digit to active-low seven-segment encoder with a blank override.
module sseg_digit_enc
  import disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: default assignment first so every path drives seg and no latch is inferred.
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) begin
      seg = SEG_DIGIT[digit];
    end
  end

endmodule

// File: rtl/sseg_field_display.sv
// Multi-field two-digit seven-segment controller with shared blink and field-edit select.
// Optional zero-reached alert FSM is compiled in when DISP_ALERT_EN is defined.
module sseg_field_display
  import disp_pkg::*;
#(
  parameter int NUM_FIELDS   = 3,
  parameter int FIELD_W      = 7,
  parameter int TOTAL_PERIOD = 25_000_000,
  parameter int ON_TIME      = 20_000_000
)(
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_FIELDS*FIELD_W-1:0]     values,
  input  logic                              enable,
  input  logic [sel_w(NUM_FIELDS)-1:0]      sel,
  input  logic                              ack,
  output logic [NUM_FIELDS*14-1:0]          hex,
  output logic                              alert
);

  localparam int SEL_W = sel_w(NUM_FIELDS);
  localparam int BC_W  = $clog2(TOTAL_PERIOD);
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_FIELDS);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(TOTAL_PERIOD - 1);
  localparam logic [BC_W-1:0]  BC_ON   = BC_W'(ON_TIME);

  logic [SEL_W-1:0]        w_sel_eff;
  logic [SEL_W-1:0]        r_sel;
  logic                    w_sel_chg;
  logic [BC_W-1:0]         r_bc;
  logic [BC_W-1:0]         w_phase;
  logic [BC_W-1:0]         w_bc_next;
  logic                    w_vis;
  logic                    w_blink_act;
  logic                    w_alert_on;
  logic [NUM_FIELDS*14-1:0] w_hex_next;
  logic [NUM_FIELDS*14-1:0] r_hex;

  assign w_sel_eff = (sel > MAX_SEL) ? '0 : sel;
  assign w_sel_chg = (w_sel_eff != r_sel);

  // A select change restarts the phase this very cycle, so the new field shows at once.
  assign w_phase     = w_sel_chg ? '0 : r_bc;
  assign w_vis       = (w_phase < BC_ON);
  assign w_blink_act = (w_sel_eff != '0) || w_alert_on;
  assign w_bc_next   = !w_blink_act        ? '0 :
                       (w_phase == BC_LAST) ? '0 : w_phase + 1'b1;

`ifdef DISP_ALERT_EN
  alert_state_t r_state;
  logic         w_allz;

  assign w_allz     = (values == '0);
  assign w_alert_on = (r_state == ALERT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (!w_allz) r_state <= ARMED;
        ARMED:   if (w_allz)  r_state <= ALERT;
        ALERT: begin
          // Acknowledge takes priority over values leaving zero.
          if (ack)          r_state <= LOCK;
          else if (!w_allz) r_state <= ARMED;
        end
        LOCK:    if (!w_allz) r_state <= ARMED;
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  logic w_unused_ack;

  assign w_unused_ack = ack;
  assign w_alert_on   = 1'b0;
`endif

  assign alert = w_alert_on;

  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    logic [FIELD_W-1:0] w_val;
    logic               w_blank;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;

    assign w_val   = values[gi*FIELD_W +: FIELD_W];
    assign w_blank = !enable
                   || (int'(w_val) > 99)
                   || (!w_vis && (w_alert_on || (w_sel_eff == SEL_W'(gi + 1))));
    assign w_tens  = 4'(int'(w_val) / 10);
    assign w_ones  = 4'(int'(w_val) % 10);

    sseg_digit_enc u_ones (
      .digit (w_ones),
      .blank (w_blank),
      .seg   (w_hex_next[gi*14 +: 7])
    );

    sseg_digit_enc u_tens (
      .digit (w_tens),
      .blank (w_blank),
      .seg   (w_hex_next[gi*14+7 +: 7])
    );
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
    if (reset) begin
      r_hex <= '1;
      r_sel <= '0;
      r_bc  <= '0;
    end else begin
      r_hex <= w_hex_next;
      r_sel <= w_sel_eff;
      r_bc  <= w_bc_next;
    end
  end

  assign hex = r_hex;

endmodule

// File: tb/tb_sseg_field_display.sv
// Self-checking bench for sseg_field_display: directed steps plus randomized traffic against a reference model.
module tb_sseg_field_display;

  localparam int NF = 3;
  localparam int FW = 7;
  localparam int TP = 10;
  localparam int OT = 6;

`ifdef DISP_ALERT_EN
  localparam bit ALERT_ON = 1'b1;
`else
  localparam bit ALERT_ON = 1'b0;
`endif

  localparam logic [13:0] F0_VIS = {7'h79, 7'h24};  // 12
  localparam logic [13:0] F1_VIS = {7'h30, 7'h19};  // 34
  localparam logic [13:0] F2_VIS = {7'h12, 7'h02};  // 56
  localparam logic [41:0] Z_VIS  = {6{7'h40}};
  localparam logic [41:0] ALL_BLANK = {42{1'b1}};

  logic              clk = 1'b0;
  logic              reset;
  logic [NF*FW-1:0]  values;
  logic              enable;
  logic [1:0]        sel;
  logic              ack;
  logic [NF*14-1:0]  hex;
  logic              alert;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  localparam int S_IDLE = 0, S_ARMED = 1, S_ALERT = 2, S_LOCK = 3;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int          m_cyc;
  int          m_start;
  int          m_prev_sel;
  bit          m_prev_act;
  int          m_state;
  logic [41:0] m_hex;
  logic        m_alert;

  sseg_field_display #(
    .NUM_FIELDS   (NF),
    .FIELD_W      (FW),
    .TOTAL_PERIOD (TP),
    .ON_TIME      (OT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .values (values),
    .enable (enable),
    .sel    (sel),
    .ack    (ack),
    .hex    (hex),
    .alert  (alert)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] pack3(input int f0, input int f1, input int f2);
    return {7'(f2), 7'(f1), 7'(f0)};
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    int  sel_eff;
    bit  alert_now;
    bit  active;
    bit  vis;
    bit  allz;
    if (reset) begin
      m_hex      = ALL_BLANK;
      m_state    = S_IDLE;
      m_prev_sel = 0;
      m_prev_act = 1'b0;
    end else begin
      sel_eff   = (int'(sel) > NF) ? 0 : int'(sel);
      alert_now = ALERT_ON && (m_state == S_ALERT);
      active    = (sel_eff != 0) || alert_now;
      if (sel_eff != m_prev_sel || !m_prev_act) m_start = m_cyc;
      vis = ((m_cyc - m_start) % TP) < OT;
      for (int i = 0; i < NF; i++) begin
        int  v;
        bit  blank;
        v     = int'(values[i*FW +: FW]);
        blank = !enable || v > 99 || (!vis && (alert_now || sel_eff == i + 1));
        m_hex[i*14 +: 14] = blank ? 14'h3FFF : {seg_tab[v / 10], seg_tab[v % 10]};
      end
      allz = (values == '0);
      case (m_state)
        S_IDLE:  if (!allz) m_state = S_ARMED;
        S_ARMED: if (allz)  m_state = S_ALERT;
        S_ALERT: if (ack) m_state = S_LOCK; else if (!allz) m_state = S_ARMED;
        default: if (!allz) m_state = S_ARMED;
      endcase
      m_prev_sel = sel_eff;
      m_prev_act = active;
    end
    m_alert = ALERT_ON && (m_state == S_ALERT);
    m_cyc++;
  endtask

  task automatic step(input logic [20:0] v, input logic en, input logic [1:0] s,
                      input logic a, input logic rst);
    values = v;
    enable = en;
    sel    = s;
    ack    = a;
    reset  = rst;
    @(posedge clk);
    model_edge();
    #1;
    check("hex", {22'd0, hex}, {22'd0, m_hex});
    check("alert", {63'd0, alert}, {63'd0, m_alert});
  endtask

  initial begin
    logic [20:0] rv;
    logic        ren;
    logic [1:0]  rsel;
    m_cyc = 0; m_start = 0; m_prev_sel = 0; m_prev_act = 1'b0;
    m_state = S_IDLE; m_hex = ALL_BLANK; m_alert = 1'b0;
    values = '0; enable = 1'b0; sel = '0; ack = 1'b0; reset = 1'b1;
    #1;

    // Reset state
    step('0, 1'b0, 2'd0, 1'b0, 1'b1);
    step('0, 1'b0, 2'd0, 1'b0, 1'b1);
    check("reset_hex", {22'd0, hex}, {22'd0, ALL_BLANK});
    check("reset_alert", {63'd0, alert}, 64'd0);

    // Basic display 12/34/56
    step(pack3(12, 34, 56), 1'b1, 2'd0, 1'b0, 1'b0);
    check("f0_ones", {57'd0, hex[6:0]}, 64'h24);
    check("f0_tens", {57'd0, hex[13:7]}, 64'h79);
    check("f1_f2", {36'd0, hex[41:14]}, {36'd0, F2_VIS, F1_VIS});

    // Blink field 1: visible 6, blank 4
    for (int t = 0; t < 10; t++) begin
      step(pack3(12, 34, 56), 1'b1, 2'd2, 1'b0, 1'b0);
      check("blink_f1", {50'd0, hex[27:14]}, {50'd0, (t < OT) ? F1_VIS : 14'h3FFF});
      check("steady_f0", {50'd0, hex[13:0]}, {50'd0, F0_VIS});
      check("steady_f2", {50'd0, hex[41:28]}, {50'd0, F2_VIS});
    end
    for (int t = 0; t < 8; t++) step(pack3(12, 34, 56), 1'b1, 2'd2, 1'b0, 1'b0);
    check("mid_blank_f1", {50'd0, hex[27:14]}, {50'd0, 14'h3FFF});
    step(pack3(12, 34, 56), 1'b1, 2'd3, 1'b0, 1'b0);
    check("sel3_f2_vis", {50'd0, hex[41:28]}, {50'd0, F2_VIS});
    check("sel3_f1_vis", {50'd0, hex[27:14]}, {50'd0, F1_VIS});

    // Out-of-range value blanks only its field
    step(pack3(100, 34, 56), 1'b1, 2'd0, 1'b0, 1'b0);
    check("over99_f0", {50'd0, hex[13:0]}, {50'd0, 14'h3FFF});
    check("over99_rest", {36'd0, hex[41:14]}, {36'd0, F2_VIS, F1_VIS});
    step(pack3(99, 127, 0), 1'b1, 2'd0, 1'b0, 1'b0);
    check("edge_99", {50'd0, hex[13:0]}, {50'd0, 7'h10, 7'h10});

    // Enable low blanks everything
    step(pack3(12, 34, 56), 1'b0, 2'd1, 1'b0, 1'b0);
    check("disable", {22'd0, hex}, {22'd0, ALL_BLANK});

    // Alert: nonzero then all-zero
    step(pack3(1, 0, 0), 1'b1, 2'd0, 1'b0, 1'b0);
    step(pack3(1, 0, 0), 1'b1, 2'd0, 1'b0, 1'b0);
    step('0, 1'b1, 2'd0, 1'b0, 1'b0);
    check("alert_rise", {63'd0, alert}, {63'd0, ALERT_ON});
    for (int t = 0; t < 10; t++) begin
      step('0, 1'b1, 2'd0, 1'b0, 1'b0);
      if (t == OT) check("alert_blink", {22'd0, hex}, {22'd0, ALERT_ON ? ALL_BLANK : Z_VIS});
    end
    step('0, 1'b1, 2'd0, 1'b1, 1'b0);
    check("ack_lock", {63'd0, alert}, 64'd0);
    step('0, 1'b1, 2'd0, 1'b0, 1'b0);
    check("lock_zero_hold", {63'd0, alert}, 64'd0);
    step(pack3(5, 0, 0), 1'b1, 2'd0, 1'b0, 1'b0);
    step('0, 1'b1, 2'd0, 1'b0, 1'b0);
    check("alert_rearm", {63'd0, alert}, {63'd0, ALERT_ON});

    // Ack together with nonzero values: ack wins
    step(pack3(7, 0, 0), 1'b1, 2'd0, 1'b1, 1'b0);
    check("ack_wins", {63'd0, alert}, 64'd0);
    step(pack3(7, 0, 0), 1'b1, 2'd0, 1'b0, 1'b0);
    check("lock_to_armed", {63'd0, alert}, 64'd0);

    // Reset during alert and blink
    step('0, 1'b1, 2'd0, 1'b0, 1'b0);
    for (int t = 0; t < 8; t++) step('0, 1'b1, 2'd2, 1'b0, 1'b0);
    step('0, 1'b1, 2'd2, 1'b0, 1'b1);
    check("rst_mid_hex", {22'd0, hex}, {22'd0, ALL_BLANK});
    check("rst_mid_alert", {63'd0, alert}, 64'd0);
    for (int t = 0; t < 15; t++) begin
      step('0, 1'b1, 2'd0, 1'b0, 1'b0);
      check("zero_after_rst", {63'd0, alert}, 64'd0);
    end

    // Randomized traffic against the model
    rv = pack3(12, 34, 56); ren = 1'b1; rsel = 2'd0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 3) == 0) rv = '0;
        else rv = pack3($urandom_range(0, 110), $urandom_range(0, 110), $urandom_range(0, 110));
      end
      if ($urandom_range(0, 7) == 0) rsel = 2'($urandom_range(0, 3));
      ren = ($urandom_range(0, 9) != 0);
      step(rv, ren, rsel, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
